// File: rtl/store_split_ctrl.sv
// Store write sequencer: aligns a store to byte lanes and emits one or two word beats to the DM port.
// Latency 1 from acceptance to mem_req; each beat held until mem_ack; st_ready low while busy or pulsing st_done.
module store_split_ctrl #(
    parameter bit SPLIT_EN = 1'b1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              st_done,
    output logic              misalign_err,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       hi_data_q, hi_data_d;
    logic [3:0]        hi_strb_q, hi_strb_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [3:0]  size_mask;
    logic [31:0] data_mask;
    logic [7:0]  strb_full;
    logic [63:0] data_full;
    logic        crossing;
    logic        illegal;

    // Upper lanes of st_data are masked so unstrobed lanes of wdata stay zero.
    always_comb begin
        size_mask = 4'b0000;
        data_mask = 32'h0000_0000;
        case (st_size)
            2'b00: begin size_mask = 4'b0001; data_mask = 32'h0000_00ff; end
            2'b01: begin size_mask = 4'b0011; data_mask = 32'h0000_ffff; end
            2'b10: begin size_mask = 4'b1111; data_mask = 32'hffff_ffff; end
            default: begin size_mask = 4'b0000; data_mask = 32'h0000_0000; end
        endcase
        strb_full = {4'b0000, size_mask} << st_addr[1:0];
        data_full = {32'h0000_0000, st_data & data_mask} << {st_addr[1:0], 3'b000};
        crossing  = |strb_full[7:4];
        illegal   = (st_size == 2'b11);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        hi_data_d = hi_data_q;
        hi_strb_d = hi_strb_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (st_valid && st_ready) begin
                    if (illegal || (crossing && !SPLIT_EN)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d   = ST_BEAT0;
                        addr_d    = {st_addr[ADDR_W-1:2], 2'b00};
                        wdata_d   = data_full[31:0];
                        wstrb_d   = strb_full[3:0];
                        hi_data_d = data_full[63:32];
                        hi_strb_d = strb_full[7:4];
                    end
                end
            end
            ST_BEAT0: begin
                if (mem_ack) begin
                    if (|hi_strb_q) begin
                        state_d = ST_BEAT1;
                        addr_d  = addr_q + ADDR_W'(4);
                        wdata_d = hi_data_q;
                        wstrb_d = hi_strb_q;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_BEAT1: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            hi_data_q <= '0;
            hi_strb_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            hi_data_q <= hi_data_d;
            hi_strb_q <= hi_strb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // No acceptance during the st_done cycle, so stores never overlap their completion.
    assign st_ready     = (state_q == ST_IDLE) && !done_q;
    assign busy         = ~st_ready;
    assign mem_req      = (state_q != ST_IDLE);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;
    assign st_done      = done_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_store_split_ctrl.sv
// Directed bench for store_split_ctrl: split and no-split instances, hand-computed beats.
module tb_store_split_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_valid1 = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        mem_ack = 1'b0;
    logic        mem_ack1 = 1'b0;

    logic        st_ready, mem_req, st_done, misalign_err, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        st_ready1, mem_req1, st_done1, misalign_err1, busy1;
    logic [31:0] mem_addr1, mem_wdata1;
    logic [3:0]  mem_wstrb1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_split_ctrl #(.SPLIT_EN(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .st_done(st_done), .misalign_err(misalign_err), .busy(busy)
    );

    store_split_ctrl #(.SPLIT_EN(1'b0), .ADDR_W(32)) dut_nosplit (
        .clk(clk), .rst(rst),
        .st_valid(st_valid1), .st_ready(st_ready1),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .mem_req(mem_req1), .mem_ack(mem_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1),
        .st_done(st_done1), .misalign_err(misalign_err1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a store for exactly one accepting edge; returns 1 ns after it.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        st_valid = 1'b1;
        step();
        st_valid = 1'b0;
    endtask

    // Checks a beat on every cycle it is held, acking on the last one.
    task automatic expect_beat(input string tag, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d, input int hold);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_req"},  mem_req,   1'b1);
            chk({tag, "_addr"}, mem_addr,  a);
            chk({tag, "_strb"}, mem_wstrb, s);
            chk({tag, "_data"}, mem_wdata, d);
            chk({tag, "_done"}, st_done,   1'b0);
            if (i == hold - 1) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"},  st_done,      1'b1);
        chk({tag, "_err"},   misalign_err, 1'b0);
        chk({tag, "_req"},   mem_req,      1'b0);
        chk({tag, "_rdy"},   st_ready,     1'b0);
        step();
        chk({tag, "_done0"}, st_done,      1'b0);
        chk({tag, "_rdy1"},  st_ready,     1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", st_ready, 1'b1);
        chk("rst_in_req",   mem_req,  1'b0);
        rst = 1'b0;
        step();
        chk("rst_ready", st_ready,     1'b1);
        chk("rst_busy",  busy,         1'b0);
        chk("rst_req",   mem_req,      1'b0);
        chk("rst_done",  st_done,      1'b0);
        chk("rst_err",   misalign_err, 1'b0);
        chk("rst_addr",  mem_addr,     32'h0);
        chk("rst_data",  mem_wdata,    32'h0);
        chk("rst_strb",  mem_wstrb,    4'h0);

        // Aligned word, immediate ack.
        issue(32'h0000_1000, 32'hAABB_CCDD, 2'b10);
        chk("sw_busy", busy, 1'b1);
        expect_beat("sw", 32'h0000_1000, 4'b1111, 32'hAABB_CCDD, 1);
        expect_done("sw");

        // Bytes: top lane, and a lane with junk upper data bits masked off.
        issue(32'h0000_1003, 32'h0000_00EE, 2'b00);
        expect_beat("sb3", 32'h0000_1000, 4'b1000, 32'hEE00_0000, 1);
        expect_done("sb3");
        issue(32'h0000_2001, 32'h1234_56EE, 2'b00);
        expect_beat("sb1", 32'h0000_2000, 4'b0010, 32'h0000_EE00, 1);
        expect_done("sb1");

        // Word crossing into the next word, split into two beats.
        issue(32'h0000_1003, 32'hAABB_CCDD, 2'b10);
        expect_beat("swx0", 32'h0000_1000, 4'b1000, 32'hDD00_0000, 1);
        expect_beat("swx1", 32'h0000_1004, 4'b0111, 32'h00AA_BBCC, 1);
        expect_done("swx");

        // Same crossing store with splitting disabled.
        st_addr = 32'h0000_1003; st_data = 32'hAABB_CCDD; st_size = 2'b10;
        st_valid1 = 1'b1;
        step();
        st_valid1 = 1'b0;
        chk("nosplit_req",  mem_req1,      1'b0);
        chk("nosplit_err",  misalign_err1, 1'b1);
        chk("nosplit_done", st_done1,      1'b1);
        step();
        chk("nosplit_err0",  misalign_err1, 1'b0);
        chk("nosplit_done0", st_done1,      1'b0);
        chk("nosplit_req0",  mem_req1,      1'b0);
        chk("nosplit_rdy",   st_ready1,     1'b1);

        // Half at the top of the address space, slow ack; beat1 wraps to 0.
        issue(32'hFFFF_FFFF, 32'h0000_1234, 2'b01);
        expect_beat("shw0", 32'hFFFF_FFFC, 4'b1000, 32'h3400_0000, 4);
        expect_beat("shw1", 32'h0000_0000, 4'b0001, 32'h0000_0012, 4);
        expect_done("shw");

        // Ack while idle does nothing.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_req",  mem_req, 1'b0);
        chk("idle_ack_done", st_done, 1'b0);

        // Reset mid BEAT1 with ack withheld.
        issue(32'h0000_1003, 32'hAABB_CCDD, 2'b10);
        expect_beat("rb0", 32'h0000_1000, 4'b1000, 32'hDD00_0000, 1);
        chk("rb1_req", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rb_req",   mem_req,  1'b0);
        chk("rb_ready", st_ready, 1'b1);
        chk("rb_done",  st_done,  1'b0);
        chk("rb_addr",  mem_addr, 32'h0);
        #1 rst = 1'b0;
        step();
        chk("rb_done_after", st_done, 1'b0);
        chk("rb_req_after",  mem_req, 1'b0);

        // Illegal size.
        issue(32'h0000_3000, 32'h5555_5555, 2'b11);
        chk("ill_err",  misalign_err, 1'b1);
        chk("ill_done", st_done,      1'b1);
        chk("ill_req",  mem_req,      1'b0);
        step();
        chk("ill_err0", misalign_err, 1'b0);
        chk("ill_req0", mem_req,      1'b0);
        chk("ill_rdy",  st_ready,     1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
